// File: rtl/wm_pkg.sv
// Shared types and constants for the wash-cycle sequencer: phase codes, water-height and
// hot/cold codes, latched-settings record and the default time-base parameters.
package wm_pkg;

   typedef enum logic [2:0] {
      PhIdle  = 3'd0,
      PhFill  = 3'd1,
      PhWash  = 3'd2,
      PhDrain = 3'd3,
      PhRinse = 3'd4,
      PhDry   = 3'd5,
      PhDone  = 3'd6
   } wm_phase_e;

   localparam logic [1:0] HeightLow  = 2'd0;
   localparam logic [1:0] HeightMid  = 2'd1;
   localparam logic [1:0] HeightHigh = 2'd2;

   localparam logic [1:0] HcBoth = 2'd0;
   localparam logic [1:0] HcCold = 2'd1;
   localparam logic [1:0] HcHot  = 2'd2;

   localparam int unsigned TickDivDefault  = 125_000_000;
   localparam int unsigned FillUnitDefault = 2;

   typedef struct packed {
      logic [7:0] wash_time;
      logic [7:0] rinse_time;
      logic [7:0] dry_time;
      logic [7:0] rinse_num;
      logic [1:0] height;
      logic [1:0] hot_cold;
   } wm_cfg_t;

   function automatic logic [1:0] norm_height(logic [1:0] h);
      return (h == 2'd3) ? HeightHigh : h;
   endfunction

   function automatic logic [1:0] norm_hot_cold(logic [1:0] hc);
      return (hc == 2'd3) ? HcBoth : hc;
   endfunction

endpackage

// File: rtl/wm_run_if.sv
// Control, settings and status bundle of the wash-cycle sequencer.
interface wm_run_if;
   logic       start;
   logic       abort;
   logic       pause;
   logic [7:0] cfg_wash_time;
   logic [7:0] cfg_rinse_time;
   logic [7:0] cfg_dry_time;
   logic [7:0] cfg_rinse_num;
   logic [1:0] cfg_water_height;
   logic [1:0] cfg_hot_cold;
   logic       busy;
   logic       paused;
   logic       done;
   logic [2:0] phase;
   logic       led_wash;
   logic       led_rinse;
   logic       led_dry;
   logic       valve_hot;
   logic       valve_cold;
   logic       motor;
   logic       drain;
   logic [7:0] fnd_val;
   logic [7:0] rinse_left;

   modport master (
      output start, abort, pause, cfg_wash_time, cfg_rinse_time, cfg_dry_time, cfg_rinse_num,
             cfg_water_height, cfg_hot_cold,
      input  busy, paused, done, phase, led_wash, led_rinse, led_dry, valve_hot, valve_cold,
             motor, drain, fnd_val, rinse_left
   );

   modport slave (
      input  start, abort, pause, cfg_wash_time, cfg_rinse_time, cfg_dry_time, cfg_rinse_num,
             cfg_water_height, cfg_hot_cold,
      output busy, paused, done, phase, led_wash, led_rinse, led_dry, valve_hot, valve_cold,
             motor, drain, fnd_val, rinse_left
   );
endinterface

// File: rtl/wm_tick_gen.sv
// Time-base prescaler: one-cycle tick every TICK_DIV enabled cycles, synchronous clear.
module wm_tick_gen #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            at_top;

   assign at_top = (cnt_q == CntW'(TICK_DIV - 1));
   // Not gated by clr: the tick that ends a phase is what triggers the clear.
   assign tick   = en && at_top;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_top ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wm_run.sv
// Wash-cycle sequencer: fill/wash/drain, repeated rinses, dry, done on a divided time base.
// Optional pause/resume is built when WM_PAUSE_EN is defined.
module wm_run
   import wm_pkg::*;
#(
   parameter int unsigned TICK_DIV  = TickDivDefault,
   parameter int unsigned FILL_UNIT = FillUnitDefault
) (
   input logic     clk,
   input logic     rstn,
   wm_run_if.slave bus
);

   localparam int unsigned MaxDur = (3 * FILL_UNIT > 255) ? 3 * FILL_UNIT : 255;
   localparam int unsigned RemW   = $clog2(MaxDur + 1);

   wm_phase_e       state_q, state_d, next_ph;
   wm_cfg_t         cfg_q, cfg_d, new_cfg, dur_cfg;
   logic [RemW-1:0] rem_q, rem_d;
   logic [7:0]      rinse_left_q, rinse_left_d, rl_dec;
   logic            rinse_stage_q, rinse_stage_d, next_rinse;
   logic            paused_q, paused_d;
   logic            busy, run, tick, clr, enter, advance;

   function automatic logic rinse_en(wm_cfg_t c);
      return (c.rinse_time != 8'd0) && (c.rinse_num != 8'd0);
   endfunction

   function automatic wm_phase_e tail_phase(wm_cfg_t c);
      return (c.dry_time != 8'd0) ? PhDry : PhDone;
   endfunction

   function automatic logic [RemW-1:0] phase_dur(wm_phase_e ph, wm_cfg_t c);
      logic [RemW-1:0] d;
      d = '0;
      case (ph)
         PhFill, PhDrain: d = RemW'((32'(c.height) + 32'd1) * FILL_UNIT);
         PhWash:          d = RemW'(c.wash_time);
         PhRinse:         d = RemW'(c.rinse_time);
         PhDry:           d = RemW'(c.dry_time);
         default:         d = '0;
      endcase
      return d;
   endfunction

   assign busy = (state_q != PhIdle);
   assign run  = !paused_q;

   wm_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk (clk),
      .rstn(rstn),
      .clr (clr),
      .en  (busy && run),
      .tick(tick)
   );

   always_comb begin
      new_cfg = '{wash_time:  bus.cfg_wash_time,
                  rinse_time: bus.cfg_rinse_time,
                  dry_time:   bus.cfg_dry_time,
                  rinse_num:  bus.cfg_rinse_num,
                  height:     norm_height(bus.cfg_water_height),
                  hot_cold:   norm_hot_cold(bus.cfg_hot_cold)};
      dur_cfg       = (state_q == PhIdle) ? new_cfg : cfg_q;
      state_d       = state_q;
      cfg_d         = cfg_q;
      rem_d         = rem_q;
      rinse_left_d  = rinse_left_q;
      rinse_stage_d = rinse_stage_q;
      next_ph       = PhIdle;
      next_rinse    = 1'b0;
      enter         = 1'b0;
      clr           = 1'b0;
      advance       = tick && (rem_q == RemW'(1));
      rl_dec        = rinse_left_q - 8'd1;

      unique case (state_q)
         PhIdle: begin
            if (bus.start) begin
               cfg_d        = new_cfg;
               rinse_left_d = bus.cfg_rinse_num;
               enter        = 1'b1;
               if (new_cfg.wash_time != 8'd0) begin
                  next_ph = PhFill;
               end else if (rinse_en(new_cfg)) begin
                  next_ph    = PhFill;
                  next_rinse = 1'b1;
               end else begin
                  next_ph = tail_phase(new_cfg);
               end
            end
         end
         PhFill: begin
            enter      = advance;
            next_ph    = rinse_stage_q ? PhRinse : PhWash;
            next_rinse = rinse_stage_q;
         end
         PhWash, PhRinse: begin
            enter      = advance;
            next_ph    = PhDrain;
            next_rinse = rinse_stage_q;
         end
         PhDrain: begin
            enter = advance;
            // Leaving a rinse drain consumes one repetition before deciding what follows.
            if (rinse_stage_q) begin
               if (advance) rinse_left_d = rl_dec;
               next_rinse = (rl_dec != 8'd0);
            end else begin
               next_rinse = rinse_en(cfg_q);
            end
            next_ph = next_rinse ? PhFill : tail_phase(cfg_q);
         end
         PhDry: begin
            enter   = advance;
            next_ph = PhDone;
         end
         PhDone: begin
            state_d = PhIdle;
         end
         default: begin
            state_d = PhIdle;
         end
      endcase

      if (enter) begin
         state_d       = next_ph;
         rinse_stage_d = next_rinse;
         rem_d         = phase_dur(next_ph, dur_cfg);
         clr           = 1'b1;
      end else if (tick && (rem_q != '0)) begin
         rem_d = rem_q - RemW'(1);
      end

      if (bus.abort) begin
         state_d       = PhIdle;
         cfg_d         = '0;
         rem_d         = '0;
         rinse_left_d  = '0;
         rinse_stage_d = 1'b0;
         clr           = 1'b1;
      end

`ifdef WM_PAUSE_EN
      paused_d = paused_q;
      if (bus.pause && busy) paused_d = !paused_q;
      if (bus.abort || (state_d == PhIdle)) paused_d = 1'b0;
`else
      paused_d = 1'b0;
`endif
   end

`ifndef WM_PAUSE_EN
   logic unused_pause;
   assign unused_pause = bus.pause;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= PhIdle;
         cfg_q         <= '0;
         rem_q         <= '0;
         rinse_left_q  <= '0;
         rinse_stage_q <= 1'b0;
         paused_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cfg_q         <= cfg_d;
         rem_q         <= rem_d;
         rinse_left_q  <= rinse_left_d;
         rinse_stage_q <= rinse_stage_d;
         paused_q      <= paused_d;
      end
   end

   // Actuators are forced off while paused; indicators keep showing where the run stopped.
   assign bus.busy       = busy;
   assign bus.paused     = paused_q;
   assign bus.done       = (state_q == PhDone);
   assign bus.phase      = state_q;
   assign bus.led_wash   = !rinse_stage_q && (state_q inside {PhFill, PhWash, PhDrain});
   assign bus.led_rinse  = rinse_stage_q && (state_q inside {PhFill, PhRinse, PhDrain});
   assign bus.led_dry    = (state_q == PhDry);
   assign bus.valve_hot  = run && (state_q == PhFill) && !rinse_stage_q &&
                           (cfg_q.hot_cold != HcCold);
   assign bus.valve_cold = run && (state_q == PhFill) &&
                           (rinse_stage_q || (cfg_q.hot_cold != HcHot));
   assign bus.motor      = run && (state_q inside {PhWash, PhRinse, PhDry});
   assign bus.drain      = run && (state_q inside {PhDrain, PhDry});
   assign bus.fnd_val    = 8'(rem_q);
   assign bus.rinse_left = rinse_left_q;

endmodule
